// File: rtl/exe_wb_merge.sv
// exe_wb_merge: merges single-cycle ALU results and load results onto the
// one register-file write port. Loads always win; ALU results that lose
// arbitration wait in an in-order FIFO of DEPTH entries.
// Optional forwarding lookup over pending results: define WB_FWD_EN.
module exe_wb_merge #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush_in,
   input  logic        alu_en_in,
   input  logic [4:0]  alu_rd_in,
   input  logic [31:0] alu_result_in,
   output logic        alu_stall_out,
   input  logic        mem_en_in,
   input  logic [4:0]  mem_rd_in,
   input  logic [31:0] mem_data_in,
`ifdef WB_FWD_EN
   input  logic [4:0]  fwd_rs_in,
   output logic        fwd_hit_out,
   output logic [31:0] fwd_data_out,
`endif
   output logic        wb_en_out,
   output logic [4:0]  wb_rd_out,
   output logic [31:0] wb_data_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    rd_q   [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          wb_en_q, wb_en_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   logic [31:0]   wb_data_q, wb_data_d;

   logic full, empty, mem_vld, alu_vld, pop, bypass, push;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   // rd 0 results are architecturally dead; treat them as never valid
   assign mem_vld = mem_en_in && (mem_rd_in != 5'd0);
   // stall depends on registered count only, so a same-cycle pop never
   // makes room for the incoming ALU result
   assign alu_vld = alu_en_in && (alu_rd_in != 5'd0) && !flush_in && !full;
   assign pop     = !mem_vld && !flush_in && !empty;
   assign bypass  = !mem_vld && empty && alu_vld;
   assign push    = alu_vld && !bypass;

   assign alu_stall_out = full;
   assign wb_en_out     = wb_en_q;
   assign wb_rd_out     = wb_rd_q;
   assign wb_data_out   = wb_data_q;

   // next-state: writeback selection and FIFO pointer/count update
   always_comb begin
      wb_en_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (mem_vld) begin
         wb_en_d   = 1'b1;
         wb_rd_d   = mem_rd_in;
         wb_data_d = mem_data_in;
      end else if (pop) begin
         wb_en_d   = 1'b1;
         wb_rd_d   = rd_q[head_q];
         wb_data_d = data_q[head_q];
      end else if (bypass) begin
         wb_en_d   = 1'b1;
         wb_rd_d   = alu_rd_in;
         wb_data_d = alu_result_in;
      end
      if (pop)  head_d = head_q + AW'(1);
      if (push) tail_d = tail_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // control and writeback registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         wb_en_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         wb_en_q   <= wb_en_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   // FIFO storage; validity is tracked by pointers/count, so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[tail_q]   <= alu_rd_in;
         data_q[tail_q] <= alu_result_in;
      end
   end

`ifdef WB_FWD_EN
   // forwarding: wb stage is lowest priority, then FIFO oldest->youngest so
   // the youngest matching entry overrides earlier hits
   always_comb begin
      fwd_hit_out  = 1'b0;
      fwd_data_out = '0;
      if (fwd_rs_in != 5'd0) begin
         if (wb_en_q && (wb_rd_q == fwd_rs_in)) begin
            fwd_hit_out  = 1'b1;
            fwd_data_out = wb_data_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (rd_q[head_q + AW'(i)] == fwd_rs_in)) begin
               fwd_hit_out  = 1'b1;
               fwd_data_out = data_q[head_q + AW'(i)];
            end
         end
      end
   end
`endif

endmodule

// File: doc/exe_wb_merge.md
Name: exe_wb_merge

Overview:
- Writeback-side consumer of the single-cycle ALU result bus (en / rd / 32-bit result).
- Merges ALU results with load results from the memory unit into the one register-file write port. Memory has fixed priority.
- ALU results that lose arbitration wait in a small in-order FIFO. Upstream issue is stalled when the FIFO is full.
- Optionally provides a forwarding lookup over pending results.

Parameters:
- DEPTH, 4, ALU result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush_in  in  1  pipeline flush; drops queued and incoming ALU results
- alu_en_in  in  1  ALU result valid
- alu_rd_in  in  5  ALU destination register
- alu_result_in  in  32  ALU result
- alu_stall_out  out  1  FIFO full; upstream must hold alu_en_in low
- mem_en_in  in  1  load result valid (never back-pressured)
- mem_rd_in  in  5  load destination register
- mem_data_in  in  32  load data
- wb_en_out  out  1  register-file write enable (registered)
- wb_rd_out  out  5  write address (registered)
- wb_data_out  out  32  write data (registered)
- fwd_rs_in  in  5  forwarding query register (WB_FWD_EN only)
- fwd_hit_out  out  1  pending result found (WB_FWD_EN only)
- fwd_data_out  out  32  youngest pending value for fwd_rs_in (WB_FWD_EN only)

Behaviour:
- Reset (rstn=0 at posedge): FIFO empty, pointers and count 0, wb_en_out=0, wb_rd_out=0, wb_data_out=0. Reset mid-operation discards all queued entries.
- Latency: 1 cycle. Selection made in cycle N appears on the wb_* outputs in cycle N+1. wb_en_out is high for exactly one cycle per written result.
- rd==0 filter: any result with rd 0 is discarded at input (never queued, never written).
- Per-cycle selection priority:
  1. mem_en_in → write mem result.
  2. Else FIFO non-empty → pop head and write it.
  3. Else alu_en_in → write ALU input directly (bypass, not enqueued).
  4. Else wb_en_out=0; wb_rd_out and wb_data_out hold their previous values.
- Enqueue: ALU input (valid, rd≠0, no flush) is pushed to the tail unless consumed by bypass.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - Pointers wrap modulo DEPTH.
- alu_stall_out = (count==DEPTH), combinational from registered count.
  - alu_en_in while full is a protocol violation; the input is dropped and count never exceeds DEPTH.
  - A pop in the full cycle does not free a slot for that same cycle's ALU input. Stall is based on count only.
- flush_in:
  - Empties the FIFO at the clock edge.
  - Ignores alu_en_in that cycle; no FIFO pop occurs.
  - mem_en_in is still written (loads are older than flushed ALU ops).
  - A flush with no mem gives wb_en_out=0 next cycle.
- Ordering: ALU results retire in issue order. The issue scoreboard guarantees no in-flight mem/ALU pair targets the same rd, so cross-source reordering is legal.

Optional Feature:
- Macro WB_FWD_EN.
- Defined:
  - fwd_* ports exist.
  - Combinational search of valid FIFO entries, youngest first, then the registered wb stage (when wb_en_out=1).
  - First rd match gives fwd_hit_out=1 and fwd_data_out=its data.
  - fwd_rs_in==0 or no match gives fwd_hit_out=0 and fwd_data_out=0.
- Not defined:
  - fwd_* ports are absent and no comparator logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset with rstn=0 for 2 cycles, then ALU en, rd=3, result 0x0000_00AA, no mem → next cycle wb_en_out=1, wb_rd_out=3, wb_data_out=0xAA, count stays 0.
- Same cycle: mem rd=5 data 0x1111 and ALU rd=6 data 0x2222 → cycle+1 writes r5=0x1111; cycle+2 writes r6=0x2222.
- mem_en held 6 cycles while ALU issues rd=1..4 (DEPTH=4) → alu_stall_out=1 after the 4th push; when mem drops, writes r1,r2,r3,r4 in order on consecutive cycles; stall clears the cycle after the first pop.
- FIFO holds 2 entries, flush_in=1 with mem rd=7 data 0x77 and ALU rd=8 → next cycle writes only r7=0x77; following cycle wb_en_out=0 and count=0.
- ALU rd=0 result 0xDEAD with empty FIFO → wb_en_out stays 0, count stays 0.
- WB_FWD_EN: queue r9=0x1, then r9=0x2, mem busy, fwd_rs_in=9 → fwd_hit_out=1, fwd_data_out=0x2; fwd_rs_in=0 → fwd_hit_out=0, fwd_data_out=0.
